// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - word-wide request/acknowledge data bus between the LSU and data memory
interface load_store_unit_if #(
  parameter int WIDTH = 32
);
  logic             bus_req;
  logic             bus_we;
  logic [WIDTH-1:0] bus_addr;
  logic [WIDTH-1:0] bus_wdata;
  logic [3:0]       bus_wstrb;
  logic             bus_ack;
  logic [WIDTH-1:0] bus_rdata;

  modport master (
    output bus_req,
    output bus_we,
    output bus_addr,
    output bus_wdata,
    output bus_wstrb,
    input  bus_ack,
    input  bus_rdata
  );

  modport slave (
    input  bus_req,
    input  bus_we,
    input  bus_addr,
    input  bus_wdata,
    input  bus_wstrb,
    output bus_ack,
    output bus_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - MEM-stage load/store unit: lane steering, load extension, misalign and timeout detection
module load_store_unit #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
  input  logic [WIDTH-1:0]  MEM_alu_out,
  input  logic [WIDTH-1:0]  MEM_mem_in,
  input  logic [2:0]        MEM_MemLen,
  input  logic              MEM_MemRead,
  input  logic              MEM_MemWrite,
  output logic [WIDTH-1:0]  MEM_mem_out,
  output logic              MemBusy,
  output logic              MisalignErr,
  output logic              BusErr,
  load_store_unit_if.master bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  // Count value reached during the last REQ cycle allowed to wait for an ack
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  logic [1:0]       state_q, state_d;
  logic             req_q, req_d;
  logic             we_q, we_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [3:0]       wstrb_q, wstrb_d;
  logic [1:0]       size_q, size_d;
  logic             sgn_q, sgn_d;
  logic [1:0]       off_q, off_d;
  logic [TO_W-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             mis_q, mis_d;
  logic             berr_q, berr_d;

  logic             access;
  logic             misaligned;
  logic             start;
  logic             timeout_hit;
  logic [1:0]       req_size;
  logic [3:0]       st_wstrb;
  logic [WIDTH-1:0] st_wdata;
  logic [WIDTH-1:0] ld_shift;
  logic [WIDTH-1:0] ld_data;

  // Classify the incoming request; undefined length codes fall through to word
  always_comb begin
    access = EN & (MEM_MemRead | MEM_MemWrite);
    case (MEM_MemLen[1:0])
      2'b00:   req_size = SZ_B;
      2'b01:   req_size = SZ_H;
      default: req_size = SZ_W;
    endcase
    misaligned = ((req_size == SZ_H) & MEM_alu_out[0]) |
                 ((req_size == SZ_W) & (MEM_alu_out[1:0] != 2'b00));
    start      = RST & (state_q == S_IDLE) & access & ~misaligned;
  end

  // Steer store data onto every lane it may land in and enable only the addressed bytes
  always_comb begin
    case (req_size)
      SZ_B: begin
        st_wstrb = 4'b0001 << MEM_alu_out[1:0];
        st_wdata = {(WIDTH/8){MEM_mem_in[7:0]}};
      end
      SZ_H: begin
        st_wstrb = 4'b0011 << {MEM_alu_out[1], 1'b0};
        st_wdata = {(WIDTH/16){MEM_mem_in[15:0]}};
      end
      default: begin
        st_wstrb = 4'b1111;
        st_wdata = MEM_mem_in;
      end
    endcase
  end

  // Right-align the addressed byte/halfword of the returned word, then extend it
  always_comb begin
    ld_shift = bus.bus_rdata >> {off_q, 3'b000};
    case (size_q)
      SZ_B:    ld_data = {{(WIDTH-8){sgn_q & ld_shift[7]}}, ld_shift[7:0]};
      SZ_H:    ld_data = {{(WIDTH-16){sgn_q & ld_shift[15]}}, ld_shift[15:0]};
      default: ld_data = ld_shift;
    endcase
  end

  assign timeout_hit = (cnt_q == TO_LAST);

  // Access sequencer: IDLE accepts, REQ waits for ack or timeout, DONE lets the pipeline advance
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    size_d  = size_q;
    sgn_d   = sgn_q;
    off_d   = off_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    mis_d   = 1'b0;
    berr_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (access) begin
          if (misaligned) begin
            mis_d = 1'b1;
            out_d = '0;
          end else begin
            state_d = S_REQ;
            req_d   = 1'b1;
            we_d    = MEM_MemWrite;
            addr_d  = {MEM_alu_out[WIDTH-1:2], 2'b00};
            wdata_d = st_wdata;
            wstrb_d = MEM_MemWrite ? st_wstrb : 4'b0000;
            size_d  = req_size;
            sgn_d   = ~MEM_MemLen[2];
            off_d   = MEM_alu_out[1:0];
            cnt_d   = '0;
          end
        end
      end
      S_REQ: begin
        if (bus.bus_ack) begin
          state_d = S_DONE;
          req_d   = 1'b0;
          if (!we_q) begin
            out_d = ld_data;
          end
        end else if (timeout_hit) begin
          state_d = S_DONE;
          req_d   = 1'b0;
          berr_d  = 1'b1;
          out_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // State register; reset abandons any outstanding access
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= 4'b0000;
      size_q  <= SZ_W;
      sgn_q   <= 1'b0;
      off_q   <= 2'b00;
      cnt_q   <= '0;
      out_q   <= '0;
      mis_q   <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      size_q  <= size_d;
      sgn_q   <= sgn_d;
      off_q   <= off_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      mis_q   <= mis_d;
      berr_q  <= berr_d;
    end
  end

  assign MemBusy       = RST & (start | (state_q == S_REQ));
  assign MEM_mem_out   = out_q;
  assign MisalignErr   = mis_q;
  assign BusErr        = berr_q;
  assign bus.bus_req   = req_q;
  assign bus.bus_we    = we_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_wdata = wdata_q;
  assign bus.bus_wstrb = wstrb_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit
module tb_load_store_unit;
  localparam int TO = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        EN = 1'b0;
  logic [31:0] MEM_alu_out = '0;
  logic [31:0] MEM_mem_in = '0;
  logic [2:0]  MEM_MemLen = '0;
  logic        MEM_MemRead = 1'b0;
  logic        MEM_MemWrite = 1'b0;
  logic [31:0] MEM_mem_out;
  logic        MemBusy;
  logic        MisalignErr;
  logic        BusErr;

  int checks = 0;
  int errors = 0;

  load_store_unit_if #(.WIDTH(32)) bus_if ();

  load_store_unit #(.WIDTH(32), .TIMEOUT(TO), .TO_W(8)) dut (
    .CLK(CLK), .RST(RST), .EN(EN),
    .MEM_alu_out(MEM_alu_out), .MEM_mem_in(MEM_mem_in), .MEM_MemLen(MEM_MemLen),
    .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite),
    .MEM_mem_out(MEM_mem_out), .MemBusy(MemBusy), .MisalignErr(MisalignErr), .BusErr(BusErr),
    .bus(bus_if)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          busy;
    int          reqs;
    int          mis;
    int          berr;
    logic [31:0] out;
    logic        we;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } exp_t;

  typedef struct {
    logic        en;
    logic        wr;
    logic        rd;
    logic [2:0]  len;
    logic [31:0] addr;
    logic [31:0] d;
    logic [31:0] rdata;
    int          ack_at;
    exp_t        e;
  } vec_t;

  typedef struct {
    int          busy;
    int          reqs;
    int          mis;
    int          berr;
    logic [31:0] out;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        stable;
  } res_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference: derived from access size, alignment and byte arithmetic
  function automatic exp_t model(input logic en, input logic wr, input logic rd, input logic [2:0] len,
                                 input logic [31:0] addr, input logic [31:0] d, input logic [31:0] rdata,
                                 input int ack_at, input logic [31:0] prev);
    exp_t e;
    int size;
    int off;
    logic [31:0] mask;
    logic [31:0] v;
    e = '{busy: 0, reqs: 0, mis: 0, berr: 0, out: prev, we: 1'b0, wstrb: 4'h0, wdata: 32'h0};
    if (!(en && (rd || wr))) return e;
    size = (len[1:0] == 2'b00) ? 1 : (len[1:0] == 2'b01) ? 2 : 4;
    off  = int'(addr[1:0]);
    if ((addr % size) != 0) begin
      e.mis = 1;
      e.out = 32'h0;
      return e;
    end
    e.we = wr;
    if (ack_at < TO) begin
      e.reqs = ack_at + 1;
      e.busy = ack_at + 2;
    end else begin
      e.reqs = TO;
      e.busy = TO + 1;
      e.berr = 1;
      e.out  = 32'h0;
    end
    if (wr) begin
      e.wstrb = 4'(((1 << size) - 1) << off);
      for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = d[8*(i % size) +: 8];
    end else if (ack_at < TO) begin
      mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
      v = (rdata >> (8 * off)) & mask;
      if (!len[2] && size < 4 && v[8*size-1]) v = v | ~mask;
      e.out = v;
    end
    return e;
  endfunction

  // Plays one pipeline instruction: holds the request while MemBusy, acks on the ack_at-th REQ cycle
  task automatic run_access(input logic en, input logic wr, input logic rd, input logic [2:0] len,
                            input logic [31:0] addr, input logic [31:0] d, input logic [31:0] rdata,
                            input int ack_at, output res_t r);
    logic hold;
    r = '{busy: 0, reqs: 0, mis: 0, berr: 0, out: 32'h0, addr: 32'h0, we: 1'b0, wstrb: 4'h0,
          wdata: 32'h0, stable: 1'b1};
    hold = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge CLK);
      if (hold) begin
        EN = en; MEM_MemWrite = wr; MEM_MemRead = rd; MEM_MemLen = len;
        MEM_alu_out = addr; MEM_mem_in = d;
      end else begin
        EN = 1'b0; MEM_MemWrite = 1'b0; MEM_MemRead = 1'b0; MEM_MemLen = 3'($urandom);
        MEM_alu_out = $urandom; MEM_mem_in = $urandom;
      end
      bus_if.bus_ack = 1'b0;
      bus_if.bus_rdata = $urandom;
      #1;
      if (MisalignErr) r.mis++;
      if (BusErr) r.berr++;
      if (MemBusy) r.busy++;
      if (bus_if.bus_req) begin
        if (r.reqs == 0) begin
          r.addr = bus_if.bus_addr; r.we = bus_if.bus_we;
          r.wstrb = bus_if.bus_wstrb; r.wdata = bus_if.bus_wdata;
        end else if (r.addr !== bus_if.bus_addr || r.we !== bus_if.bus_we ||
                     r.wstrb !== bus_if.bus_wstrb || r.wdata !== bus_if.bus_wdata) begin
          r.stable = 1'b0;
        end
        if (r.reqs == ack_at) begin
          bus_if.bus_ack = 1'b1;
          bus_if.bus_rdata = rdata;
        end
        r.reqs++;
      end
      if (!MemBusy) hold = 1'b0;
    end
    r.out = MEM_mem_out;
  endtask

  task automatic compare(input string tag, input res_t r, input exp_t e, input logic [31:0] addr);
    chk({tag, " busy"}, 32'(r.busy), 32'(e.busy));
    chk({tag, " reqs"}, 32'(r.reqs), 32'(e.reqs));
    chk({tag, " mis"},  32'(r.mis),  32'(e.mis));
    chk({tag, " berr"}, 32'(r.berr), 32'(e.berr));
    chk({tag, " out"},  r.out, e.out);
    if (e.reqs > 0) begin
      chk({tag, " addr"},   r.addr, {addr[31:2], 2'b00});
      chk({tag, " we"},     32'(r.we), 32'(e.we));
      chk({tag, " wstrb"},  32'(r.wstrb), 32'(e.wstrb));
      chk({tag, " stable"}, 32'(r.stable), 32'd1);
      if (e.we) chk({tag, " wdata"}, r.wdata, e.wdata);
    end
  endtask

  vec_t        tbl [15];
  res_t        r;
  exp_t        e;
  logic [31:0] model_out;

  initial begin
    //          en    wr    rd    len     addr         d            rdata        ack  busy reqs mis berr out           we    wstrb wdata
    tbl[0]  = '{1'b1, 1'b0, 1'b1, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 0,  '{2, 1, 0, 0, 32'hDEADBEEF, 1'b0, 4'h0, 32'h0}};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 3'b000, 32'h103, 32'h0,        32'h80FF0000, 0,  '{2, 1, 0, 0, 32'hFFFFFF80, 1'b0, 4'h0, 32'h0}};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 3'b100, 32'h103, 32'h0,        32'h80FF0000, 0,  '{2, 1, 0, 0, 32'h00000080, 1'b0, 4'h0, 32'h0}};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 3'b001, 32'h102, 32'h1234ABCD, 32'h0,        0,  '{2, 1, 0, 0, 32'h00000080, 1'b1, 4'hC, 32'hABCDABCD}};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 3'b010, 32'h101, 32'h0,        32'h0,        0,  '{0, 0, 1, 0, 32'h0,        1'b0, 4'h0, 32'h0}};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 3'b001, 32'h102, 32'h0,        32'h80010000, 2,  '{4, 3, 0, 0, 32'hFFFF8001, 1'b0, 4'h0, 32'h0}};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 3'b101, 32'h101, 32'h0,        32'h0,        0,  '{0, 0, 1, 0, 32'h0,        1'b0, 4'h0, 32'h0}};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 3'b000, 32'h201, 32'h00000055, 32'h0,        1,  '{3, 2, 0, 0, 32'h0,        1'b1, 4'h2, 32'h55555555}};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 3'b101, 32'h202, 32'h0,        32'hF00D1234, 0,  '{2, 1, 0, 0, 32'h0000F00D, 1'b0, 4'h0, 32'h0}};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 3'b010, 32'h200, 32'h0,        32'h11111111, 99, '{5, 4, 0, 1, 32'h0,        1'b0, 4'h0, 32'h0}};
    tbl[10] = '{1'b1, 1'b0, 1'b1, 3'b010, 32'h300, 32'h0,        32'h12345678, 3,  '{5, 4, 0, 0, 32'h12345678, 1'b0, 4'h0, 32'h0}};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 3'b010, 32'h400, 32'h0,        32'hAAAAAAAA, 0,  '{0, 0, 0, 0, 32'h12345678, 1'b0, 4'h0, 32'h0}};
    tbl[12] = '{1'b1, 1'b1, 1'b1, 3'b010, 32'h010, 32'hCAFEF00D, 32'h0,        0,  '{2, 1, 0, 0, 32'h12345678, 1'b1, 4'hF, 32'hCAFEF00D}};
    tbl[13] = '{1'b1, 1'b0, 1'b1, 3'b111, 32'h021, 32'h0,        32'h0,        0,  '{0, 0, 1, 0, 32'h0,        1'b0, 4'h0, 32'h0}};
    tbl[14] = '{1'b1, 1'b0, 1'b1, 3'b011, 32'h040, 32'h0,        32'h87654321, 0,  '{2, 1, 0, 0, 32'h87654321, 1'b0, 4'h0, 32'h0}};

    bus_if.bus_ack = 1'b0;
    bus_if.bus_rdata = '0;

    // reset state
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    #1;
    chk("rst bus_req", 32'(bus_if.bus_req), 32'd0);
    chk("rst bus_we", 32'(bus_if.bus_we), 32'd0);
    chk("rst bus_wstrb", 32'(bus_if.bus_wstrb), 32'd0);
    chk("rst out", MEM_mem_out, 32'd0);
    chk("rst busy", 32'(MemBusy), 32'd0);
    chk("rst mis", 32'(MisalignErr), 32'd0);
    chk("rst berr", 32'(BusErr), 32'd0);
    RST = 1'b1;

    // directed vectors
    model_out = 32'h0;
    for (int i = 0; i < 15; i++) begin
      run_access(tbl[i].en, tbl[i].wr, tbl[i].rd, tbl[i].len, tbl[i].addr, tbl[i].d,
                 tbl[i].rdata, tbl[i].ack_at, r);
      compare($sformatf("vec%0d", i), r, tbl[i].e, tbl[i].addr);
      model_out = tbl[i].e.out;
    end

    // randomized accesses against the reference model
    for (int i = 0; i < 60; i++) begin
      logic        en, wr, rd;
      logic [2:0]  len;
      logic [31:0] addr, d, rdata;
      int          ack_at, kind;
      en = ($urandom_range(0, 9) != 0);
      kind = $urandom_range(0, 3);
      rd = (kind == 0) || (kind == 2);
      wr = (kind == 1) || (kind == 2);
      len = 3'($urandom_range(0, 7));
      addr = $urandom; d = $urandom; rdata = $urandom;
      ack_at = $urandom_range(0, 5);
      e = model(en, wr, rd, len, addr, d, rdata, ack_at, model_out);
      run_access(en, wr, rd, len, addr, d, rdata, ack_at, r);
      compare($sformatf("rnd%0d", i), r, e, addr);
      model_out = e.out;
    end

    // reset while a request is outstanding; a late ack must be ignored
    @(negedge CLK);
    EN = 1'b1; MEM_MemRead = 1'b1; MEM_MemWrite = 1'b0; MEM_MemLen = 3'b010; MEM_alu_out = 32'h500;
    bus_if.bus_ack = 1'b0;
    @(negedge CLK);
    #1;
    chk("midrst req before", 32'(bus_if.bus_req), 32'd1);
    @(negedge CLK);
    RST = 1'b0; EN = 1'b0; MEM_MemRead = 1'b0;
    @(negedge CLK);
    #1;
    chk("midrst req", 32'(bus_if.bus_req), 32'd0);
    chk("midrst busy", 32'(MemBusy), 32'd0);
    chk("midrst out", MEM_mem_out, 32'd0);
    RST = 1'b1;
    bus_if.bus_ack = 1'b1;
    bus_if.bus_rdata = 32'hFFFF_FFFF;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      #1;
      chk($sformatf("lateack req%0d", c), 32'(bus_if.bus_req), 32'd0);
      chk($sformatf("lateack busy%0d", c), 32'(MemBusy), 32'd0);
      chk($sformatf("lateack out%0d", c), MEM_mem_out, 32'd0);
      chk($sformatf("lateack berr%0d", c), 32'(BusErr), 32'd0);
    end
    bus_if.bus_ack = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
